uart_receiver: RTL and testbench

- Serial-to-parallel UART receiver: 8N1 frames (1 start, 8 data LSB-first, 1 stop); the receive-side counterpart of the on-chip UART transmitter.
- Oversamples the asynchronous serial_in line with the system clock and samples each bit at mid-symbol.
- Presents each received byte on a ready/valid interface with a one-entry holding register, and flags framing and overrun errors.

---
 rtl/uart_receiver.sv | 148 ++++++++++++++
 tb/tb_uart_receiver.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: oversampled serial line, mid-symbol sampling, one-entry
// ready/valid holding register with framing-error and overrun pulses.
module uart_receiver #(
  parameter int unsigned CLOCK_FREQ = 125_000_000,
  parameter int unsigned BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int unsigned SymbolEdgeTime = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned SampleTime     = SymbolEdgeTime / 2;
  localparam int unsigned CntW           = $clog2(SymbolEdgeTime);

  localparam logic [CntW-1:0] SymLast    = CntW'(SymbolEdgeTime - 1);
  localparam logic [CntW-1:0] SampleLast = CntW'(SampleTime - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  state_e state_q, state_d;

  logic            sync_q;
  logic            rx_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;

  logic [7:0] data_q;
  logic       valid_q;
  logic       framing_error_q;
  logic       overrun_q;

  logic sym_tick;
  logic shift_en;
  logic data_entry;
  logic stop_good;
  logic stop_bad;
  logic cnt_clr;
  logic load;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 1'b1;
      rx_q   <= 1'b1;
    end else begin
      sync_q <= serial_in;
      rx_q   <= sync_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (!rx_q) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == SampleLast) state_d = rx_q ? StIdle : StData;
      end
      StData: begin
        if (sym_tick && (bit_idx_q == 3'd7)) state_d = StStop;
      end
      StStop: begin
        // A good stop returns to idle mid-bit so the next start edge is not missed.
        if (sym_tick) state_d = rx_q ? StIdle : StBreak;
      end
      StBreak: begin
        if (rx_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sym_tick   = (cnt_q == SymLast);
    shift_en   = (state_q == StData) && sym_tick;
    data_entry = (state_q != StData) && (state_d == StData);
    stop_good  = (state_q == StStop) && sym_tick && rx_q;
    stop_bad   = (state_q == StStop) && sym_tick && !rx_q;
    cnt_clr    = (state_d != state_q) || shift_en;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      cnt_q <= cnt_clr ? '0 : cnt_q + 1'b1;
      if (data_entry) begin
        bit_idx_q <= '0;
      end else if (shift_en) begin
        bit_idx_q <= bit_idx_q + 3'd1;
      end
      if (shift_en) begin
        shift_q[bit_idx_q] <= rx_q;
      end
    end
  end

  // The holding register may accept a new byte in the same cycle it is drained.
  assign load = stop_good && (!valid_q || data_out_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q          <= '0;
      valid_q         <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      if (load) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (data_out_ready) begin
        valid_q <= 1'b0;
      end
      framing_error_q <= stop_bad;
      overrun_q       <= stop_good && !load;
    end
  end

  assign data_out       = data_q;
  assign data_out_valid = valid_q;
  assign framing_error  = framing_error_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: table of single frames plus hand-written
// sequences for back-to-back, backpressure, glitch, latency and reset cases.
module tb_uart_receiver;

  localparam int unsigned ClkFreq = 125_000_000;
  localparam int unsigned Baud    = 1_250_000;
  localparam int          Sym     = 100;
  localparam int          Lat     = 2 + 50 + 9 * Sym + 1;

  logic       clk;
  logic       reset;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       framing_error;
  logic       overrun;

  uart_receiver #(
    .CLOCK_FREQ(ClkFreq),
    .BAUD_RATE (Baud)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .serial_in     (serial_in),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] hs_q[$];
  int fe_cnt, ovr_cnt, valid_cycles;

  always @(negedge clk) begin
    if (reset) begin
      if (data_out_valid) valid_cycles++;
      if (data_out_valid && data_out_ready) hs_q.push_back(data_out);
      if (framing_error) fe_cnt++;
      if (overrun) ovr_cnt++;
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         hold_low;
    int         exp_hs;
    int         exp_fe;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    hs_q.delete();
    fe_cnt       = 0;
    ovr_cnt      = 0;
    valid_cycles = 0;
  endtask

  // Called at a negedge; drives one 8N1 frame LSB first.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int hold_low);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      serial_in = bits[i];
      repeat (Sym) @(negedge clk);
    end
    if (hold_low > 0) repeat (hold_low) @(negedge clk);
    serial_in = 1'b1;
  endtask

  function automatic logic [31:0] first_hs();
    return (hs_q.size() > 0) ? 32'(hs_q[0]) : 32'hffff_ffff;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    logic [7:0] b2b[3];
    logic [7:0] rb;
    int cyc;

    vecs[0] = '{data: 8'hA5, stop: 1'b1, hold_low: 0,    exp_hs: 1, exp_fe: 0};
    vecs[1] = '{data: 8'h81, stop: 1'b0, hold_low: 5000, exp_hs: 0, exp_fe: 1};
    vecs[2] = '{data: 8'h42, stop: 1'b1, hold_low: 0,    exp_hs: 1, exp_fe: 0};
    vecs[3] = '{data: 8'h5A, stop: 1'b1, hold_low: 0,    exp_hs: 1, exp_fe: 0};
    vecs[4] = '{data: 8'hC3, stop: 1'b1, hold_low: 0,    exp_hs: 1, exp_fe: 0};
    b2b[0] = 8'h00;
    b2b[1] = 8'hFF;
    b2b[2] = 8'h3C;

    reset          = 1'b0;
    serial_in      = 1'b1;
    data_out_ready = 1'b1;
    clear_mon();
    repeat (3) @(negedge clk);
    check("reset_data", 32'(data_out), 32'h0);
    check("reset_valid", 32'(data_out_valid), 32'h0);
    check("reset_fe", 32'(framing_error), 32'h0);
    check("reset_ovr", 32'(overrun), 32'h0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      clear_mon();
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].hold_low);
      repeat (Sym) @(negedge clk);
      check($sformatf("vec%0d_hs", v), 32'(hs_q.size()), 32'(vecs[v].exp_hs));
      check($sformatf("vec%0d_data", v), first_hs(),
            vecs[v].exp_hs > 0 ? 32'(vecs[v].data) : 32'hffff_ffff);
      check($sformatf("vec%0d_vcyc", v), 32'(valid_cycles), 32'(vecs[v].exp_hs));
      check($sformatf("vec%0d_fe", v), 32'(fe_cnt), 32'(vecs[v].exp_fe));
      check($sformatf("vec%0d_ovr", v), 32'(ovr_cnt), 32'h0);
    end

    // Latency from the first synchronizer capture of the start bit.
    clear_mon();
    cyc = 0;
    fork
      send_frame(8'h96, 1'b1, 0);
      begin
        @(posedge clk);
        while (cyc < 3000) begin
          @(negedge clk);
          if (data_out_valid) break;
          @(posedge clk);
          cyc++;
        end
      end
    join
    repeat (Sym) @(negedge clk);
    check("lat_in_window", 32'((cyc >= Lat - 1) && (cyc <= Lat + 1)), 32'h1);
    check("lat_data", first_hs(), 32'h96);

    // Back-to-back frames with no idle gap.
    clear_mon();
    for (int i = 0; i < 3; i++) send_frame(b2b[i], 1'b1, 0);
    repeat (Sym) @(negedge clk);
    check("b2b_count", 32'(hs_q.size()), 32'h3);
    for (int i = 0; i < 3; i++) begin
      rb = (hs_q.size() > i) ? hs_q[i] : 8'hxx;
      check($sformatf("b2b_data%0d", i), 32'(rb), 32'(b2b[i]));
    end
    check("b2b_ovr", 32'(ovr_cnt), 32'h0);

    // Backpressure: second byte overruns, first byte is preserved.
    clear_mon();
    data_out_ready = 1'b0;
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    repeat (Sym) @(negedge clk);
    check("bp_ovr", 32'(ovr_cnt), 32'h1);
    check("bp_data", 32'(data_out), 32'h11);
    check("bp_valid", 32'(data_out_valid), 32'h1);
    check("bp_no_hs", 32'(hs_q.size()), 32'h0);
    @(posedge clk);
    #1 data_out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    check("bp_valid_clr", 32'(data_out_valid), 32'h0);
    @(negedge clk);
    check("bp_hs_count", 32'(hs_q.size()), 32'h1);
    check("bp_hs_data", first_hs(), 32'h11);

    // Short low glitch must be rejected silently.
    clear_mon();
    serial_in = 1'b0;
    repeat (20) @(negedge clk);
    serial_in = 1'b1;
    repeat (2 * Sym) @(negedge clk);
    check("glitch_hs", 32'(hs_q.size()), 32'h0);
    check("glitch_fe", 32'(fe_cnt), 32'h0);
    check("glitch_ovr", 32'(ovr_cnt), 32'h0);
    send_frame(8'h5A, 1'b1, 0);
    repeat (Sym) @(negedge clk);
    check("glitch_next", first_hs(), 32'h5A);

    // Reset asserted mid data bit 4, between clock edges, with a byte held.
    data_out_ready = 1'b0;
    send_frame(8'h77, 1'b1, 0);
    repeat (Sym) @(negedge clk);
    check("rst_pre_valid", 32'(data_out_valid), 32'h1);
    serial_in = 1'b0;
    repeat (Sym) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      serial_in = ((8'h3C >> i) & 8'h01) != 0;
      repeat ((i == 4) ? Sym / 2 : Sym) @(negedge clk);
    end
    #2 reset = 1'b0;
    #1;
    check("rst_async_data", 32'(data_out), 32'h0);
    check("rst_async_valid", 32'(data_out_valid), 32'h0);
    check("rst_async_fe", 32'(framing_error), 32'h0);
    check("rst_async_ovr", 32'(overrun), 32'h0);
    serial_in = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    data_out_ready = 1'b1;
    repeat (Sym) @(negedge clk);
    clear_mon();
    send_frame(8'hC3, 1'b1, 0);
    repeat (Sym) @(negedge clk);
    check("rst_after_count", 32'(hs_q.size()), 32'h1);
    check("rst_after_data", first_hs(), 32'hC3);
    check("rst_after_fe", 32'(fe_cnt), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
